fetch_queue: RTL
================

# fetch_queue

Decoupling buffer between the instruction-fetch stage (PC register plus instruction ROM, reset PC 0x0000_3000) and the decode stage of the pipelined CPU. It captures each fetched {PC, instruction} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. Fetch uses `f_ready` directly as its PC-update enable. A branch/jump redirect flushes all buffered entries in one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- CW, $clog2(DEPTH)+1, width of `count`
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- f_valid  in  1  fetch presents a valid {f_pc, f_instr} this cycle
- f_pc  in  32  PC of the fetched instruction
- f_instr  in  32  fetched instruction word
- f_ready  out  1  queue can accept a push; drives fetch PC enable
- flush  in  1  discard all entries (redirect); highest priority
- d_valid  out  1  head entry available to decode
- d_pc  out  32  PC of head entry
- d_instr  out  32  instruction of head entry
- d_ready  in  1  decode consumes head entry this cycle
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}; read pointer `rp`, write pointer `wp`, each $clog2(DEPTH) bits, plus occupancy counter `cnt` (CW bits).
- `f_ready` = (cnt != DEPTH). `d_valid` = (cnt != 0). Both are combinational from registered state only; neither depends on `f_valid`, `d_ready` or `flush`.
- `d_pc`/`d_instr` = entry[rp] when `d_valid` = 1; 32'h0000_0000 (nop) on both when empty.
- push = f_valid & f_ready & ~flush; pop = d_valid & d_ready & ~flush.
- push: entry[wp] <= {f_pc, f_instr}; wp <= wp+1 (mod DEPTH).
- pop: rp <= rp+1 (mod DEPTH).
- cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- flush = 1: rp <= 0, wp <= 0, cnt <= 0; concurrent push and pop are ignored. Entry contents need not be cleared.
- No bypass: a push into an empty queue is never visible on `d_*` in the same cycle.
- Full queue: `f_ready` = 0, so no push, even if a pop occurs in the same cycle.
- Pointer wrap: after DEPTH-1 the next value is 0. No other special case.
- `count` = cnt.

## Timing
- Reset (async assert): rp = 0, wp = 0, cnt = 0, all entries = 0. As a result `d_valid` = 0, `d_pc` = `d_instr` = 0, `f_ready` = 1 and `count` = 0, without waiting for a clock edge.
- Reset has priority over flush and over any handshake. Deassertion takes effect at the next rising edge. Reset mid-stream discards all contents.
- Push-to-visible latency: 1 cycle. A push at edge N gives `d_valid` = 1 after edge N with that entry at the head, if the queue was empty.
- Throughput: one push and one pop per cycle sustained while 0 < cnt < DEPTH.
- Flush asserted in cycle N: after edge N, `d_valid` = 0 and `f_ready` = 1. The first post-redirect instruction can be pushed in cycle N+1 and is visible in cycle N+2.
- `f_ready` and `d_valid` change only on clock edges or on reset assertion. This is a no-combinational-loop guarantee for the fetch enable path.

## Test plan
- Reset/idle: assert reset mid-cycle with 2 entries held -> `d_valid` = 0, `count` = 0, `f_ready` = 1, `d_instr` = 0 before the next edge.
- Fill/drain, DEPTH = 4, d_ready = 0: push PCs 0x3000, 0x3004, 0x3008, 0x300C -> `count` = 4, `f_ready` = 0. The 5th push (0x3010) is refused. Then d_ready = 1 pops 0x3000..0x300C in order, then `d_valid` = 0.
- Simultaneous push/pop at cnt = 2: `count` stays 2 and order is preserved. Run 10 cycles so pointers wrap at least twice, and check `d_pc` increments by 4 every cycle.
- Full + pop: cnt = 4, f_valid = 1, d_ready = 1 -> pop only, `count` = 3. The next cycle accepts the push.
- Flush priority: cnt = 3, flush = 1 with f_valid = 1 and d_ready = 1 -> after the edge `count` = 0 and `d_valid` = 0, and the offered entry is lost. Push 0x3040 next cycle -> `d_pc` = 0x3040 one cycle later.
- Empty no-bypass: empty queue, push 0x3000/0x2402000A with d_ready = 1 -> `d_valid` = 0 in that cycle and 1 in the next with `d_instr` = 0x2402000A.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
// -----------
// Decoupling FIFO between instruction fetch and decode. Every fetched
// {pc, instr} pair goes into a circular buffer, and decode sees the oldest
// entry. A redirect (flush) empties the buffer in one cycle.
//
// Handshake (applies to both sides): a transfer happens on a rising edge
// when valid and ready are both high and flush is low. f_ready and d_valid
// come only from registered occupancy, so they never depend on f_valid,
// d_ready or flush. This keeps the fetch PC enable free of combinational
// loops.
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous active-high reset
//   f_valid  in   fetch offers {f_pc, f_instr}
//   f_pc     in   PC of the fetched instruction
//   f_instr  in   fetched instruction word
//   f_ready  out  queue can accept a push (fetch PC enable)
//   flush    in   discard all entries; highest priority after reset
//   d_valid  out  head entry available to decode
//   d_pc     out  PC of the head entry (0 when empty)
//   d_instr  out  instruction of the head entry (0 when empty)
//   d_ready  in   decode consumes the head entry
//   count    out  current occupancy, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_valid,
  input  logic [31:0]   f_pc,
  input  logic [31:0]   f_instr,
  output logic          f_ready,
  input  logic          flush,
  output logic          d_valid,
  output logic [31:0]   d_pc,
  output logic [31:0]   d_instr,
  input  logic          d_ready,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign f_ready = (cnt_q != CW'(DEPTH));
  assign d_valid = (cnt_q != '0);
  assign count   = cnt_q;

  // An empty queue presents a nop (all zeros), not stale storage contents.
  assign d_pc    = d_valid ? pc_mem_q[rp_q]    : 32'h0000_0000;
  assign d_instr = d_valid ? instr_mem_q[rp_q] : 32'h0000_0000;

  assign push = f_valid & f_ready & ~flush;
  assign pop  = d_valid & d_ready & ~flush;

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (flush) begin
      rp_d  = '0;
      wp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      if (push) begin
        pc_mem_q[wp_q]    <= f_pc;
        instr_mem_q[wp_q] <= f_instr;
      end
    end
  end

endmodule
